// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART echo buffer.
//   - mode_e     : transform select encodings driven on the 'mode' port
//   - tx_state_e : transmit scheduler FSM states
//   - transform(): byte transform applied before a byte is queued
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_REV  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

  // Widest byte the transform supports. Callers zero-extend their data into
  // this width and truncate the result back to their own width. The
  // truncation is what makes the add mode wrap modulo 2^width.
  localparam int XFORM_W  = 32;
  localparam int XFORM_IW = $clog2(XFORM_W);

  function automatic logic [XFORM_W-1:0] transform(
    input mode_e              mode,
    input logic [XFORM_W-1:0] data,
    input int                 width,
    input logic [XFORM_W-1:0] add_value
  );
    logic [XFORM_W-1:0]  res;
    logic [XFORM_IW-1:0] dst;
    logic [XFORM_IW-1:0] src;
    res = '0;
    case (mode)
      MODE_PASS: res = data;
      MODE_ADD:  res = data + add_value;
      MODE_INV:  res = ~data;
      MODE_REV: begin
        // Reverse only the low 'width' bits; bits above stay zero.
        for (int i = 0; i < XFORM_W; i++) begin
          dst = XFORM_IW'(i);
          src = XFORM_IW'(width - 1 - i);
          if (i < width) res[dst] = data[src];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_echo_buffer_if.sv
// uart_echo_buffer_if: byte handshake between the UART cores and the buffer.
//   rx_valid/rx_data : strobe and byte from the RX core
//   tx_done          : end-of-stop-bit strobe from the TX core
//   tx_start/tx_data : one-cycle request and held byte to the TX core
// modport master: the side that owns the UART cores (board top, bench).
// modport slave : the echo buffer.
interface uart_echo_buffer_if #(
  parameter int DATA_W = 8
) ();
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_done;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;

  modport master (
    output rx_valid, rx_data, tx_done,
    input  tx_start, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_done,
    output tx_start, tx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   CLK, RST : clock, synchronous active-high reset
//   push     : write wr_data at the tail. The caller only pushes when
//              there is room or when a pop happens in the same cycle.
//   pop      : advance the head. The caller only pops when not empty.
//   rd_data  : current head entry, readable without a pop
//   count    : occupancy 0..DEPTH; full/empty decoded from it
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Its entries are only observable
  // after being written, and leaving reset off keeps it mappable to RAM.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // On push+pop when full, wr_ptr == rd_ptr. The head is read here before
  // the edge overwrites that slot.
  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: transforms received bytes, queues them and releases them
// to the TX core one at a time. An optional idle gap follows each frame.
//   CLK, RST   : clock, synchronous active-high reset
//   mode       : transform select (uart_pkg::mode_e), sampled with rx_valid
//   bus        : RX/TX handshake (uart_echo_buffer_if.slave)
//   last_rx    : last raw rx_data seen, whether it was accepted or dropped
//   fifo_count : queue occupancy 0..DEPTH
//   overflow   : sticky, set by the first dropped byte
//   drop_count : dropped bytes, saturating at 16'hFFFF
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int unsigned GAP_TICKS = 5000000,
  parameter int          ADD_VALUE = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             mode,
  uart_echo_buffer_if.slave      bus,
  output logic [DATA_W-1:0]      last_rx,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS) - 32'd1;

  tx_state_e         state;
  tx_state_e         next_state;
  logic              pop;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       gap_cnt;

  // The transform is applied at push time, so a later mode change leaves
  // already-queued bytes untouched.
  assign wr_data = DATA_W'(transform(mode_e'(mode), XFORM_W'(bus.rx_data),
                                     DATA_W, XFORM_W'(ADD_VALUE)));

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push = bus.rx_valid && (!fifo_full || pop);
  assign drop = bus.rx_valid && fifo_full && !pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ST_SEND;
        end
      end
      ST_SEND:      next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.tx_done) next_state = (GAP_TICKS != 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The counter is held at zero outside GAP, so it starts from 0 on entry.
  always_ff @(posedge CLK) begin
    if (RST || state != ST_GAP) gap_cnt <= '0;
    else                        gap_cnt <= gap_cnt + 32'd1;
  end

  // tx_start and tx_data are registered from the pop decision. tx_data only
  // changes on a pop, so it stays stable until the next tx_start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
    end else begin
      bus.tx_start <= pop;
      if (pop) bus.tx_data <= fifo_head;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_rx    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (bus.rx_valid) last_rx <= bus.rx_data;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: scoreboard bench for uart_echo_buffer with DEPTH=4,
// GAP_TICKS=4 and ADD_VALUE=1. Expected bytes are queued when stimulus is
// driven. A negedge monitor collects every tx_start and the byte it carries.
module tb_uart_echo_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] mode;
  logic [7:0] last_rx;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [15:0] drop_count;

  uart_echo_buffer_if #(.DATA_W(8)) bus ();

  uart_echo_buffer #(
    .DATA_W    (8),
    .DEPTH     (4),
    .GAP_TICKS (4),
    .ADD_VALUE (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mode       (mode),
    .bus        (bus),
    .last_rx    (last_rx),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  // At time (posedge j)+1, cyc_n == j, which names the current cycle.
  int cyc_n = 0;
  always @(posedge CLK) cyc_n <= cyc_n + 1;

  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];
  int         seen_cyc[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always @(negedge CLK) begin
    if (bus.tx_start === 1'b1) begin
      seen_q.push_back(bus.tx_data);
      seen_cyc.push_back(cyc_n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_seen(input int budget, output bit got);
    for (int i = 0; i < budget; i++) begin
      if (seen_q.size() > 0) break;
      cyc();
    end
    got = (seen_q.size() > 0);
  endtask

  task automatic pulse_done(output int d);
    d = cyc_n;
    bus.tx_done = 1'b1;
    cyc();
    bus.tx_done = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    mode = 2'd0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.tx_done = 1'b0;
    repeat (3) cyc();
    RST = 1'b0;
    cyc();
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_cmp++; if (last_rx !== 8'h00) begin n_err++; $display("FAIL reset_last_rx got %h want 00", last_rx); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
  endtask

  task automatic test_modes();
    logic [1:0] vm   [5];
    logic [7:0] vin  [5];
    logic [7:0] vexp [5];
    logic [7:0] got_d;
    logic [7:0] want_d;
    int         got_c;
    int         k;
    int         d;
    bit         got;
    vm   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
    vin  = '{8'h41, 8'h81, 8'h81, 8'h01, 8'hFF};
    vexp = '{8'h42, 8'h7E, 8'h81, 8'h80, 8'h00};
    for (int i = 0; i < 5; i++) begin
      mode = vm[i];
      k = cyc_n;
      bus.rx_valid = 1'b1;
      bus.rx_data = vin[i];
      exp_q.push_back(vexp[i]);
      cyc();
      bus.rx_valid = 1'b0;
      mode = ~vm[i];   // must not affect the byte already queued
      n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL mode%0d_count got %0d want 1", i, fifo_count); end
      wait_seen(10, got);
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL mode%0d_start got none want tx_start", i);
        exp_q.delete();
      end else begin
        got_d = seen_q.pop_front();
        got_c = seen_cyc.pop_front();
        want_d = exp_q.pop_front();
        if (got_d !== want_d) begin n_err++; $display("FAIL mode%0d_data got %h want %h", i, got_d, want_d); end
        n_cmp++; if (got_c != k + 2) begin n_err++; $display("FAIL mode%0d_latency got cycle %0d want %0d", i, got_c, k + 2); end
      end
      n_cmp++; if (last_rx !== vin[i]) begin n_err++; $display("FAIL mode%0d_last_rx got %h want %h", i, last_rx, vin[i]); end
      n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL mode%0d_start_width got %b want 0", i, bus.tx_start); end
      pulse_done(d);
      repeat (6) cyc();
    end
    mode = 2'd0;
  endtask

  task automatic test_back_to_back_gap();
    logic [7:0] b [3];
    logic [7:0] got_d;
    logic [7:0] want_d;
    int         got_c;
    int         want_c;
    int         k;
    int         d;
    bit         got;
    b = '{8'h10, 8'h20, 8'h30};
    mode = 2'd0;
    k = cyc_n;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = b[i];
      exp_q.push_back(b[i]);
      cyc();
    end
    bus.rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL gap_count got %0d want 2", fifo_count); end
    d = 0;
    for (int i = 0; i < 3; i++) begin
      wait_seen(40, got);
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL gap%0d_start got none want tx_start", i);
        break;
      end
      got_d = seen_q.pop_front();
      got_c = seen_cyc.pop_front();
      want_d = exp_q.pop_front();
      want_c = (i == 0) ? k + 2 : d + 6;
      if (got_d !== want_d) begin n_err++; $display("FAIL gap%0d_data got %h want %h", i, got_d, want_d); end
      n_cmp++; if (got_c != want_c) begin n_err++; $display("FAIL gap%0d_timing got cycle %0d want %0d", i, got_c, want_c); end
      while (cyc_n < got_c + 10) cyc();
      n_cmp++; if (bus.tx_data !== want_d) begin n_err++; $display("FAIL gap%0d_hold got %h want %h", i, bus.tx_data, want_d); end
      pulse_done(d);
    end
    exp_q.delete();
    repeat (8) cyc();
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL gap_drain_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [7:0] got_d;
    logic [7:0] want_d;
    int         got_c;
    int         k;
    int         d;
    int         d_full;
    bit         got;
    mode = 2'd0;
    k = cyc_n;
    for (int i = 0; i < 7; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'hA0 + 8'(i);
      if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
      cyc();
    end
    bus.rx_valid = 1'b0;
    n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop_count got %0d want 2", drop_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    n_cmp++; if (last_rx !== 8'hA6) begin n_err++; $display("FAIL ovf_last_rx got %h want a6", last_rx); end
    n_cmp++;
    if (seen_q.size() != 1) begin
      n_err++; $display("FAIL ovf_first_start got %0d starts want 1", seen_q.size());
    end else begin
      got_d = seen_q.pop_front();
      got_c = seen_cyc.pop_front();
      want_d = exp_q.pop_front();
      if (got_d !== want_d) begin n_err++; $display("FAIL ovf_first_data got %h want %h", got_d, want_d); end
      n_cmp++; if (got_c != k + 2) begin n_err++; $display("FAIL ovf_first_timing got cycle %0d want %0d", got_c, k + 2); end
    end

    // Push lands in the same cycle as the IDLE pop of a full FIFO.
    pulse_done(d_full);
    while (cyc_n < d_full + 5) cyc();
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hB7;
    exp_q.push_back(8'hB7);
    cyc();
    bus.rx_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fullpop_count got %0d want 4", fifo_count); end
    n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL fullpop_drop_count got %0d want 2", drop_count); end

    for (int i = 0; i < 5; i++) begin
      wait_seen(40, got);
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL drain%0d_start got none want tx_start", i);
        break;
      end
      got_d = seen_q.pop_front();
      got_c = seen_cyc.pop_front();
      want_d = exp_q.pop_front();
      if (got_d !== want_d) begin n_err++; $display("FAIL drain%0d_data got %h want %h", i, got_d, want_d); end
      if (i == 0) begin
        n_cmp++; if (got_c != d_full + 6) begin n_err++; $display("FAIL fullpop_timing got cycle %0d want %0d", got_c, d_full + 6); end
      end
      repeat (2) cyc();
      pulse_done(d);
    end
    exp_q.delete();
    repeat (8) cyc();
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got_d;
    int         got_c;
    int         k;
    int         d;
    mode = 2'd0;
    k = cyc_n;
    for (int i = 0; i < 4; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data = 8'hC0 + 8'(i);
      cyc();
    end
    bus.rx_valid = 1'b0;
    n_cmp++;
    if (seen_q.size() != 1) begin
      n_err++; $display("FAIL rst_first_start got %0d starts want 1", seen_q.size());
    end else begin
      got_d = seen_q.pop_front();
      got_c = seen_cyc.pop_front();
      if (got_d !== 8'hC0) begin n_err++; $display("FAIL rst_first_data got %h want c0", got_d); end
      n_cmp++; if (got_c != k + 2) begin n_err++; $display("FAIL rst_first_timing got cycle %0d want %0d", got_c, k + 2); end
    end
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count got %0d want 3", fifo_count); end
    RST = 1'b1;
    repeat (2) cyc();
    RST = 1'b0;
    seen_q.delete();
    seen_cyc.delete();
    pulse_done(d);   // stray tx_done from the abandoned frame, lands in IDLE
    repeat (20) cyc();
    n_cmp++; if (seen_q.size() != 0) begin n_err++; $display("FAIL rst_no_start got %0d starts want 0", seen_q.size()); end
    n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start got %b want 0", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data got %h want 00", bus.tx_data); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rst_fifo_count got %0d want 0", fifo_count); end
    n_cmp++; if (last_rx !== 8'h00) begin n_err++; $display("FAIL rst_last_rx got %h want 00", last_rx); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop_count got %0d want 0", drop_count); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back_gap();
    test_overflow_and_full_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Parametrised byte buffer and transmit scheduler between the UART receiver and UART transmitter cores on the board top level. Received bytes are transformed according to a selectable mode, queued in a FIFO, and released to the transmitter one at a time, with a configurable minimum idle gap between frames. Overflow is counted instead of silently overwriting data. The block also exposes the last raw received byte for the LED bank.

## Interface
- DATA_W, 8: byte width on the RX/TX interfaces.
- DEPTH, 16: FIFO entries; must be a power of two and at least 2.
- GAP_TICKS, 5000000: CLK cycles between tx_done and the next tx_start eligibility. 0 means back-to-back.
- ADD_VALUE, 1: constant used by the add mode, applied modulo 2^DATA_W.

Ports:
- CLK  in  1  system clock, 100 MHz on board.
- RST  in  1  reset; synchronous, active-high.
- mode  in  2  transform select: 0 pass, 1 add ADD_VALUE, 2 bitwise invert, 3 bit-reverse.
- rx_valid  in  1  one-cycle strobe from the RX core.
- rx_data  in  DATA_W  received byte; valid with rx_valid.
- tx_done  in  1  one-cycle strobe from the TX core at end of stop bit.
- tx_start  out  1  one-cycle request to the TX core.
- tx_data  out  DATA_W  byte to transmit; held stable from tx_start until tx_done.
- last_rx  out  DATA_W  last raw rx_data accepted or dropped (LED display).
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag, set on the first drop.
- drop_count  out  16  dropped bytes, saturating at 16'hFFFF.

## Operation
- Push: on rx_valid, transform(rx_data) is written at the tail. mode is sampled in the same cycle, so a later mode change does not alter queued bytes. last_rx <= rx_data unconditionally.
- Full: when fifo_count==DEPTH and no pop occurs in the same cycle, the byte is dropped. overflow <= 1 and drop_count increments until it saturates.
- Simultaneous push and pop when full: the push is accepted and the count is unchanged. Simultaneous push and pop when empty: impossible, because a pop requires a non-empty FIFO.
- TX FSM has four states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE: if fifo_count>0, pop the head into tx_data, assert tx_start, and go to SEND.
  - SEND: deassert tx_start and go to WAIT_DONE.
  - WAIT_DONE: on tx_done, go to GAP if GAP_TICKS>0, otherwise go to IDLE.
  - GAP: 32-bit counter runs from 0. When it equals GAP_TICKS-1, go to IDLE. The counter clears on entry.
- A tx_done outside WAIT_DONE is ignored.
- Reset: FIFO empty, state IDLE, gap counter 0. tx_start, tx_data, last_rx, fifo_count, overflow and drop_count are all 0. RST mid-frame abandons the frame. The TX core finishes its current byte on its own, and the resulting tx_done arrives in IDLE and is ignored.

## Timing
- rx_valid in cycle k with FIFO empty and FSM in IDLE gives tx_start high in cycle k+2 (k+1 write, k+2 registered pop and start).
- tx_start is exactly one cycle wide. tx_data is updated in the same cycle and is not changed again before the next tx_start.
- tx_done in cycle d with GAP_TICKS=G>0 means the earliest next tx_start is cycle d+G+2. With G=0 it is d+2.
- fifo_count reflects pushes and pops one cycle after the event.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package uart_pkg holds:
  - the mode encodings MODE_PASS, MODE_ADD, MODE_INV and MODE_REV;
  - the FSM state encoding;
  - the transform function, so the top level and the bench share one definition.
- One sub-module, sync_fifo (parameters DATA_W, DEPTH), owns:
  - push/pop handling, using wrap-around pointers of $clog2(DEPTH) bits plus the count;
  - full and empty flags.
- The FSM, gap counter, drop statistics and last_rx live in uart_echo_buffer.

## Test plan
- Reset, then mode=1 and rx byte 8'h41 → tx_start 2 cycles later with tx_data=8'h42; last_rx=8'h41.
- Modes 2 and 3 with byte 8'h81 → tx_data 8'h7E, then 8'h81. Byte 8'h01 in mode 3 → 8'h80. Mode 1 with 8'hFF → 8'h00 (wrap).
- GAP_TICKS=4, three bytes pushed back-to-back, tx_done returned 10 cycles after each tx_start → three tx_start pulses, each 6 cycles after the previous tx_done, data in order.
- DEPTH=4, no tx_done returned, 7 bytes pushed → first byte is popped at start, 4 are queued, 2 are dropped. Result: drop_count=2, overflow=1, fifo_count=4.
- Push while full in the same cycle as an IDLE pop → byte accepted, fifo_count stays DEPTH, no drop.
- RST asserted in WAIT_DONE with 3 bytes queued, stray tx_done after release → no tx_start, fifo_count=0, all outputs 0.
